// File: rtl/seg_buf_writer.sv
// Writer side of the segmented sample buffer: fills one SEG_LEN-word segment from a
// valid/ready stream, pulses seg_done when full, and optionally ping-pongs to the next segment.
module seg_buf_writer #(
  parameter int SEG_LEN = 30,
  parameter int NUM_SEG = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  localparam int SEG_W  = $clog2(NUM_SEG),
  localparam int OFF_W  = $clog2(SEG_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [SEG_W-1:0]  select,
  input  logic              auto_next,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              seg_done,
  output logic [SEG_W-1:0]  done_seg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(SEG_LEN - 1);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

  state_t              r_state;
  logic [OFF_W-1:0]    r_offset;
  logic [SEG_W-1:0]    r_cur_seg;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_seg_done;
  logic [SEG_W-1:0]    r_done_seg;

  logic [ADDR_W-1:0]   w_addr;
  logic [SEG_W-1:0]    w_next_seg;

  // Segment base plus offset never exceeds NUM_SEG*SEG_LEN-1, which fits ADDR_W.
  assign w_addr     = ADDR_W'(r_cur_seg) * ADDR_W'(SEG_LEN) + ADDR_W'(r_offset);
  assign w_next_seg = (r_cur_seg == LAST_SEG) ? '0 : r_cur_seg + SEG_W'(1);

  // NOTE: each output is fully assigned by a continuous assign, so no latch can be inferred.
  assign in_ready = (r_state == S_WRITE);
  assign busy     = (r_state != S_IDLE);
  assign we       = r_we;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;
  assign seg_done = r_seg_done;
  assign done_seg = r_done_seg;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_offset   <= '0;
      r_cur_seg  <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_seg_done <= 1'b0;
      r_done_seg <= '0;
    end else begin
      r_we       <= 1'b0;
      r_seg_done <= 1'b0;
      if (abort) begin
        r_state  <= S_IDLE;
        r_offset <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_cur_seg <= select;
              r_offset  <= '0;
              r_state   <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (in_valid) begin
              r_we    <= 1'b1;
              r_waddr <= w_addr;
              r_wdata <= in_data;
              if (r_offset == LAST_OFF) begin
                // Completion flags land in the same cycle as the segment's final write.
                r_offset   <= '0;
                r_state    <= S_DONE;
                r_seg_done <= 1'b1;
                r_done_seg <= r_cur_seg;
              end else begin
                r_offset <= r_offset + OFF_W'(1);
              end
            end
          end
          S_DONE: begin
            if (auto_next) begin
              r_cur_seg <= w_next_seg;
              r_state   <= S_WRITE;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/seg_buf_writer.md
Name: seg_buf_writer

Overview:
- Writer side of the 4-segment, 120-entry sample buffer; the playback reader walks the same segments via select-based start/finish ranges.
- Accepts a valid/ready word stream and writes SEG_LEN consecutive words into the selected segment (base = seg*SEG_LEN).
- Pulses seg_done when the segment is full.
- Optionally advances to the next segment so software can ping-pong read completed segments.

Parameters:
- SEG_LEN, 30, words per segment; segment k spans k*SEG_LEN .. k*SEG_LEN+SEG_LEN-1
- NUM_SEG, 4, number of segments; segment index width 2
- ADDR_W, 8, buffer address width; NUM_SEG*SEG_LEN-1 must fit
- DATA_W, 16, data word width

Ports:
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin filling segment `select`; honoured only in IDLE
- select  input  2  segment index sampled on an accepted start
- auto_next  input  1  1 = on segment completion continue with (seg+1) mod NUM_SEG; sampled in DONE
- abort  input  1  synchronous; forces IDLE from any state
- in_valid  input  1  stream word valid
- in_data  input  DATA_W  stream word
- in_ready  output  1  writer can accept a word
- we  output  1  buffer write enable, registered
- waddr  output  ADDR_W  buffer write address, registered
- wdata  output  DATA_W  buffer write data, registered
- busy  output  1  state != IDLE
- seg_done  output  1  one-cycle pulse: segment filled
- done_seg  output  2  index of last completed segment; holds until next completion

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, offset=0, cur_seg=0.
  - in_ready=0, we=0, waddr=0, wdata=0, busy=0, seg_done=0, done_seg=0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1: cur_seg<=select, offset<=0, next state WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - in_ready=1 combinationally from state; no dependence on in_valid.
  - A handshake (in_valid & in_ready) in cycle N produces, in cycle N+1: we=1, waddr=cur_seg*SEG_LEN+offset, wdata=in_data.
  - The product cur_seg*SEG_LEN+offset is computed in ADDR_W bits with no overflow by construction.
  - Handshake with offset<SEG_LEN-1: offset++.
  - Handshake with offset==SEG_LEN-1: offset<=0, next state DONE.
  - No handshake: we=0 next cycle; offset holds. Stalls of any length are allowed.
- DONE (exactly one cycle):
  - in_ready=0.
  - seg_done=1 and done_seg=cur_seg, registered. This is the same cycle as the final we for address cur_seg*SEG_LEN+SEG_LEN-1.
  - auto_next=1: cur_seg<=(cur_seg+1) mod NUM_SEG (3 wraps to 0), next state WRITE.
  - auto_next=0: next state IDLE.
- start outside IDLE is ignored. select changes outside an accepted start have no effect.
- abort=1, any state:
  - Next state IDLE, offset<=0, no seg_done.
  - A write registered from the current-cycle handshake is suppressed: we=0 next cycle.
  - done_seg is unchanged.
  - abort has priority over start and over handshakes.
- Reset mid-segment: all writes stop immediately; partial segment contents in the buffer are not cleared.
- busy=1 in WRITE and DONE.
- Throughput: 1 word/cycle in WRITE. Exactly one dead cycle (DONE) between segments in auto_next mode.

Test Plan:
- Reset, start=1 select=2, stream 30 words 0x100..0x11D back-to-back:
  - we high 30 cycles, waddr 60..89, wdata matches the stream.
  - seg_done pulses with waddr=89; done_seg=2; busy falls after DONE.
- select=3, auto_next=1, stream 62 words:
  - Addresses 90..119, then 0..29, then 30,31.
  - seg_done twice: done_seg=3, then 0.
  - in_ready=0 for exactly one cycle between segments.
- select=1 with in_valid toggling every other cycle:
  - Exactly 30 writes at 30..59, no gaps in address, no duplicate writes.
  - seg_done after the 30th accepted word only.
- start with select=0 while busy on segment 1:
  - Ignored; writes stay in 30..59; done_seg=1.
- abort asserted after 10 words of segment 0, same cycle as a handshake:
  - That 11th write is suppressed; state returns to IDLE; no seg_done.
  - A following start select=0 restarts at waddr=0.
- rstn pulled low mid-segment 2 (after 15 words):
  - All outputs 0 asynchronously.
  - After release, in_ready=0 until a new start.
